axi_port_arbiter: RTL

- Shares one AXI burst master (write or read) between two user-port controllers. Each port controller raises start/addr/len exactly as it would toward a dedicated master.
- Selects one requester and forwards its burst command to the master. Returns ready and busy only to the granted port, and multiplexes the port write data toward the master.
- Two instances are used: one in front of the AXI write master, one in front of the AXI read master. This lets two video/user streams share one DDR3 controller.

---
 rtl/axi_port_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/axi_port_arbiter.sv
// Two-port arbiter sharing one AXI burst master (write or read side).
// Forwards the winning port's burst command and routes ready/busy/wdata.
`timescale 1ns/1ps
module axi_port_arbiter #(
  parameter int ADDR_W  = 30,
  parameter int LEN_W   = 8,
  parameter int DATA_W  = 64,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s0_start,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [LEN_W-1:0]  s0_len,
  input  logic [DATA_W-1:0] s0_wdata,
  output logic              s0_ready,
  output logic              s0_busy,
  input  logic              s1_start,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [LEN_W-1:0]  s1_len,
  input  logic [DATA_W-1:0] s1_wdata,
  output logic              s1_ready,
  output logic              s1_busy,
  output logic              m_start,
  output logic [ADDR_W-1:0] m_addr,
  output logic [LEN_W-1:0]  m_len,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic              m_busy,
  output logic              grant,
  output logic              grant_valid,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t              state_q;
  logic                m_start_q;
  logic [ADDR_W-1:0]   m_addr_q;
  logic [LEN_W-1:0]    m_len_q;
  logic                grant_q;
  logic                grant_valid_q;
  logic                timeout_err_q;
  logic                last_grant_q;
  logic [CNT_W-1:0]    wd_cnt_q;

  logic                winner;
  logic [CNT_W-1:0]    wd_cnt_inc;
  logic                wd_expired;

  // On a tie, round-robin favours the port that did not finish the last burst.
  assign winner = (s0_start && s1_start) ? ((RR_MODE != 0) ? ~last_grant_q : 1'b0)
                                         : s1_start;

  assign wd_cnt_inc = wd_cnt_q + CNT_W'(1);
  assign wd_expired = (TIMEOUT != 0) && (wd_cnt_inc == CNT_W'(TIMEOUT));

  // NOTE: all state lives in this one block and uses non-blocking assignments,
  // so every register updates from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      m_start_q     <= 1'b0;
      m_addr_q      <= '0;
      m_len_q       <= '0;
      grant_q       <= 1'b0;
      grant_valid_q <= 1'b0;
      timeout_err_q <= 1'b0;
      last_grant_q  <= 1'b1;
      wd_cnt_q      <= '0;
    end else begin
      timeout_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (m_ready && (s0_start || s1_start)) begin
            grant_q       <= winner;
            m_addr_q      <= winner ? s1_addr : s0_addr;
            m_len_q       <= winner ? s1_len  : s0_len;
            grant_valid_q <= 1'b1;
            m_start_q     <= 1'b1;
            wd_cnt_q      <= '0;
            state_q       <= ISSUE;
          end
        end
        ISSUE: begin
          if (!m_ready) begin
            m_start_q <= 1'b0;
            wd_cnt_q  <= '0;
            state_q   <= BUSY;
          end else if (wd_expired) begin
            // Abort leaves last_grant alone so the same port is re-served.
            m_start_q     <= 1'b0;
            grant_valid_q <= 1'b0;
            timeout_err_q <= 1'b1;
            wd_cnt_q      <= '0;
            state_q       <= IDLE;
          end else begin
            wd_cnt_q <= wd_cnt_inc;
          end
        end
        BUSY: begin
          if (m_ready) begin
            last_grant_q  <= grant_q;
            grant_valid_q <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_start     = m_start_q;
  assign m_addr      = m_addr_q;
  assign m_len       = m_len_q;
  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign timeout_err = timeout_err_q;

  // Only the owning port sees the master; the other port sees an idle master.
  assign s0_ready = (grant_valid_q && !grant_q) ? m_ready : 1'b1;
  assign s1_ready = (grant_valid_q &&  grant_q) ? m_ready : 1'b1;
  assign s0_busy  = m_busy & grant_valid_q & ~grant_q;
  assign s1_busy  = m_busy & grant_valid_q &  grant_q;

  // Combinational so FIFO first-word data lines up with m_busy.
  assign m_wdata = grant_q ? s1_wdata : s0_wdata;

endmodule
